// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO controller: client request and
// read-domain pointer in, write pointers and status flags out.
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rd_ptr_gray;
  logic                  ovf_clr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_gray;
  logic                  fifo_full;
  logic                  almost_full;
  logic [ADDR_WIDTH-1:0] wr_level;
  logic                  overflow;

  // Client / read-domain side: drives requests, observes status.
  modport master (
    output wr_en, rd_ptr_gray, ovf_clr,
    input  wr_ptr, wr_ptr_gray, fifo_full, almost_full, wr_level, overflow
  );

  // Controller side.
  modport slave (
    input  wr_en, rd_ptr_gray, ovf_clr,
    output wr_ptr, wr_ptr_gray, fifo_full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer / full-flag controller of the async FIFO.
// The read pointer arrives in Gray code and is resynchronised here through
// a SYNC_STAGES flop chain; every output is driven straight from a flop.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DEPTH       = 8,
  parameter int AF_THRESH   = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic           wr_clk,
  input  logic           rst,
  fifo_wr_ctrl_if.slave  bus
);

  // Threshold is clamped into 1..DEPTH so a bad override cannot disable the flag.
  localparam int AF_EFF = (AF_THRESH > DEPTH) ? DEPTH :
                          ((AF_THRESH < 1) ? 1 : AF_THRESH);
  localparam logic [ADDR_WIDTH-1:0] AF_LVL  = ADDR_WIDTH'(AF_EFF);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

  // Binary to Gray: adjacent codes differ in exactly one bit.
  function automatic logic [ADDR_WIDTH-1:0] bin2gray(input logic [ADDR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: running XOR prefix starting at the MSB.
  function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
    logic [ADDR_WIDTH-1:0] b;
    b = g;
    for (int i = ADDR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [ADDR_WIDTH-1:0] wr_ptr_q,      wr_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [ADDR_WIDTH-1:0] wr_level_q,    wr_level_d;
  logic                  fifo_full_q,   fifo_full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  overflow_q,    overflow_d;

  logic                  wr_acc_s;
  logic [ADDR_WIDTH-1:0] rd_gray_s;
  logic [ADDR_WIDTH-1:0] rd_bin_s;
  logic [ADDR_WIDTH-1:0] full_gray_s;

  // Shift the incoming read Gray pointer one stage deeper each edge.
  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_d[i] = PTR_ZERO;
    end
    sync_d[0] = bus.rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Next pointer, flags and level, all derived from the registered full flag
  // and the synchronised read pointer.
  always_comb begin
    rd_gray_s = sync_q[SYNC_STAGES-1];
    rd_bin_s  = gray2bin(rd_gray_s);
    wr_acc_s  = bus.wr_en & ~fifo_full_q;

    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    wr_ptr_gray_d = bin2gray(wr_ptr_d);

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits inverted, the rest equal.
    full_gray_s = {~rd_gray_s[ADDR_WIDTH-1:ADDR_WIDTH-2], rd_gray_s[ADDR_WIDTH-3:0]};
    fifo_full_d = (wr_ptr_gray_d == full_gray_s);

    wr_level_d    = wr_ptr_d - rd_bin_s;
    almost_full_d = (wr_level_d >= AF_LVL);

    // A rejected write sets the sticky flag; setting takes priority over clearing.
    if (bus.wr_en & fifo_full_q) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; reset clears everything at once, including the synchroniser.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= PTR_ZERO;
      end
      wr_ptr_q      <= PTR_ZERO;
      wr_ptr_gray_q <= PTR_ZERO;
      wr_level_q    <= PTR_ZERO;
      fifo_full_q   <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_level_q    <= wr_level_d;
      fifo_full_q   <= fifo_full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.wr_ptr      = wr_ptr_q;
  assign bus.wr_ptr_gray = wr_ptr_gray_q;
  assign bus.wr_level    = wr_level_q;
  assign bus.fifo_full   = fifo_full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: a vector table for fill / overflow /
// drain, hand-written reset and wrap sequences, then a randomized run
// against an occupancy-counting reference model.
module tb_fifo_wr_ctrl;

  localparam int AW = 4;

  logic wr_clk = 1'b0;
  logic rst    = 1'b1;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(
    .ADDR_WIDTH(AW), .DEPTH(8), .AF_THRESH(6), .SYNC_STAGES(2)
  ) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] rd_gray;
    logic          ovf_clr;
    logic [AW-1:0] ptr;
    logic [AW-1:0] gray;
    logic [AW-1:0] level;
    logic          full;
    logic          af;
    logic          ovf;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic w, input logic [AW-1:0] r, input logic c,
                              input logic [AW-1:0] p, input logic [AW-1:0] g,
                              input logic [AW-1:0] l, input logic f, input logic a,
                              input logic o);
    vec_t v;
    v.wr_en = w; v.rd_gray = r; v.ovf_clr = c; v.ptr = p; v.gray = g;
    v.level = l; v.full = f; v.af = a; v.ovf = o;
    return v;
  endfunction

  function automatic logic [AW-1:0] to_gray(input int n);
    logic [AW-1:0] b;
    b = AW'(n);
    return b ^ (b >> 1);
  endfunction

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ptr"},   int'(bus.wr_ptr),      0);
    chk({tag, "_gray"},  int'(bus.wr_ptr_gray), 0);
    chk({tag, "_level"}, int'(bus.wr_level),    0);
    chk({tag, "_full"},  int'(bus.fifo_full),   0);
    chk({tag, "_af"},    int'(bus.almost_full), 0);
    chk({tag, "_ovf"},   int'(bus.overflow),    0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; bus.rd_ptr_gray = 4'b0000;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // ---- vector table: fill, overflow, overflow clear, drain latency, refill
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 4'd1, 4'b0001, 4'd1, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 4'b0000, 1'b0, 4'd2, 4'b0011, 4'd2, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 4'b0000, 1'b0, 4'd3, 4'b0010, 4'd3, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 4'b0000, 1'b0, 4'd4, 4'b0110, 4'd4, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 4'b0000, 1'b0, 4'd5, 4'b0111, 4'd5, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 4'b0000, 1'b0, 4'd6, 4'b0101, 4'd6, 1'b0, 1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 4'b0000, 1'b0, 4'd7, 4'b0100, 4'd7, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[9]  = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[10] = mk(1'b1, 4'b0000, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[11] = mk(1'b0, 4'b0000, 1'b1, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[12] = mk(1'b1, 4'b0000, 1'b1, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b1);
    vecs[13] = mk(1'b0, 4'b0000, 1'b1, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 4'd8, 1'b1, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 4'b0001, 1'b0, 4'd8, 4'b1100, 4'd7, 1'b0, 1'b1, 1'b0);
    vecs[17] = mk(1'b1, 4'b0001, 1'b0, 4'd9, 4'b1101, 4'd8, 1'b1, 1'b1, 1'b0);

    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0; bus.rd_ptr_gray = 4'b0000;

    // ---- reset state
    do_reset();
    chk_all_zero("reset");

    // ---- table-driven vectors
    for (int i = 0; i < 18; i++) begin
      bus.wr_en       = vecs[i].wr_en;
      bus.rd_ptr_gray = vecs[i].rd_gray;
      bus.ovf_clr     = vecs[i].ovf_clr;
      step();
      chk($sformatf("vec%0d_ptr", i),   int'(bus.wr_ptr),      int'(vecs[i].ptr));
      chk($sformatf("vec%0d_gray", i),  int'(bus.wr_ptr_gray), int'(vecs[i].gray));
      chk($sformatf("vec%0d_level", i), int'(bus.wr_level),    int'(vecs[i].level));
      chk($sformatf("vec%0d_full", i),  int'(bus.fifo_full),   int'(vecs[i].full));
      chk($sformatf("vec%0d_af", i),    int'(bus.almost_full), int'(vecs[i].af));
      chk($sformatf("vec%0d_ovf", i),   int'(bus.overflow),    int'(vecs[i].ovf));
    end

    // ---- asynchronous reset mid-cycle while writing
    bus.wr_en = 1'b1; bus.ovf_clr = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    bus.wr_en = 1'b0; bus.rd_ptr_gray = 4'b0000;
    @(negedge wr_clk);
    rst = 1'b0;
    step();
    chk("post_rst_ptr",  int'(bus.wr_ptr),      0);
    chk("post_rst_gray", int'(bus.wr_ptr_gray), 0);

    // ---- wrap: read side follows the exported Gray pointer
    begin
      logic [AW-1:0] prev_gray;
      logic [AW-1:0] prev_ptr;
      bit saw_bin_wrap  = 1'b0;
      bit saw_gray_wrap = 1'b0;
      prev_gray = bus.wr_ptr_gray;
      prev_ptr  = bus.wr_ptr;
      for (int i = 0; i < 20; i++) begin
        bus.wr_en       = 1'b1;
        bus.rd_ptr_gray = bus.wr_ptr_gray;
        step();
        chk("wrap_ptr",     int'(bus.wr_ptr), (i + 1) % 16);
        chk("wrap_hamming", $countones(bus.wr_ptr_gray ^ prev_gray), 1);
        chk("wrap_full",    int'(bus.fifo_full), 0);
        chk("wrap_level_le3", int'(bus.wr_level <= 4'd3), 1);
        if (prev_ptr == 4'b1111 && bus.wr_ptr == 4'b0000) saw_bin_wrap = 1'b1;
        if (prev_gray == 4'b1000 && bus.wr_ptr_gray == 4'b0000) saw_gray_wrap = 1'b1;
        prev_gray = bus.wr_ptr_gray;
        prev_ptr  = bus.wr_ptr;
      end
      chk("wrap_bin_seen",  int'(saw_bin_wrap),  1);
      chk("wrap_gray_seen", int'(saw_gray_wrap), 1);
    end

    // ---- randomized run against an occupancy model
    do_reset();
    begin
      int wcnt = 0;         // writes accepted into memory
      int rcnt = 0;         // reads performed by the read domain
      int rdq[$];           // read counts not yet visible to the write side
      int seen, level;
      bit m_full = 1'b0, m_ovf = 1'b0;
      bit we, clr;
      rdq.push_back(0);
      rdq.push_back(0);
      for (int cyc = 0; cyc < 10000; cyc++) begin
        we  = ($urandom_range(0, 99) < 60);
        clr = ($urandom_range(0, 99) < 5);
        if ((wcnt - rcnt) > 0 && $urandom_range(0, 99) < 50) rcnt++;
        bus.wr_en       = we;
        bus.ovf_clr     = clr;
        bus.rd_ptr_gray = to_gray(rcnt);
        step();
        // Model: the read count becomes visible two edges after it was presented.
        rdq.push_back(rcnt);
        seen = rdq.pop_front();
        if (we && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (we && !m_full) wcnt++;
        level  = (wcnt - seen) % 16;
        m_full = (level == 8);
        chk("rnd_ptr",   int'(bus.wr_ptr),      wcnt % 16);
        chk("rnd_level", int'(bus.wr_level),    level);
        chk("rnd_full",  int'(bus.fifo_full),   int'(m_full));
        chk("rnd_af",    int'(bus.almost_full), int'(level >= 6));
        chk("rnd_ovf",   int'(bus.overflow),    int'(m_ovf));
        chk("rnd_full_eq_level8", int'(bus.fifo_full == (bus.wr_level == 4'd8)), 1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
